// File: rtl/bcd_timer_ctrl.sv
// Run controller for a two-digit BCD up-counter: prescales the clock into count
// ticks, drives the counter's enable/clear and stops when the count hits a BCD target.
module bcd_timer_ctrl #(
  parameter int DIV   = 50,
  parameter int DIV_W = 6
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic       STOP,
  input  logic       CLR,
  input  logic [3:0] TGT_HI,
  input  logic [3:0] TGT_LO,
  input  logic [3:0] CNT_HI,
  input  logic [3:0] CNT_LO,
  output logic       CNT_EN,
  output logic       CNT_CLR,
  output logic       TICK,
  output logic       BUSY,
  output logic       DONE
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_PAUSE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [DIV_W-1:0] PRE_LAST = DIV_W'(DIV - 1);

  logic [2:0]       state_reg, state_next;
  logic [DIV_W-1:0] pre_reg, pre_next;
  logic [7:0]       tgt_reg, tgt_next;
  logic             clr_pend_reg;
  logic [7:0]       tgt_in, tgt_clamped;
  logic             match, tick;

  assign tgt_in = {TGT_HI, TGT_LO};

  // Out-of-range BCD digits saturate to 9 so a match is always reachable.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_clamp
      assign tgt_clamped[gi*4 +: 4] = (tgt_in[gi*4 +: 4] > 4'd9) ? 4'd9 : tgt_in[gi*4 +: 4];
    end
  endgenerate

  assign match = ({CNT_HI, CNT_LO} == tgt_reg);
  assign tick  = (state_reg == S_RUN) && (pre_reg == PRE_LAST);

  always_comb begin
    state_next = state_reg;
    if (CLR) begin
      state_next = S_IDLE;
    end else begin
      case (state_reg)
        S_IDLE:  if (START && !STOP) state_next = S_LOAD;
        S_LOAD:  state_next = S_RUN;
        S_RUN: begin
          if (match)     state_next = S_DONE;
          else if (STOP) state_next = S_PAUSE;
        end
        S_PAUSE: if (START && !STOP) state_next = S_RUN;
        S_DONE:  if (START && !STOP) state_next = S_LOAD;
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    pre_next = pre_reg;
    case (state_reg)
      S_RUN:   pre_next = tick ? '0 : pre_reg + 1'b1;
      S_LOAD:  pre_next = '0;
      S_IDLE:  pre_next = '0;
      default: pre_next = pre_reg;
    endcase
  end

  // LOAD is only ever entered from IDLE or DONE, so this is the latch edge.
  always_comb begin
    tgt_next = tgt_reg;
    if (state_next == S_LOAD && state_reg != S_LOAD) tgt_next = tgt_clamped;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg    <= S_IDLE;
      pre_reg      <= '0;
      tgt_reg      <= 8'h00;
      clr_pend_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pre_reg      <= pre_next;
      tgt_reg      <= tgt_next;
      clr_pend_reg <= CLR;
    end
  end

  assign TICK    = tick;
  assign CNT_EN  = tick && !match;
  assign CNT_CLR = (state_reg == S_LOAD) || clr_pend_reg;
  assign BUSY    = (state_reg == S_LOAD) || (state_reg == S_RUN);
  assign DONE    = (state_reg == S_DONE);

endmodule
